// File: rtl/snake_move_sequencer_if.sv
// Handshake and datapath bundle between the move sequencer and its tick/direction source,
// the shared 5-bit adder and the body/collision consumer.
interface snake_move_sequencer_if;
  logic       tick;
  logic       dir_valid;
  logic [1:0] dir;
  logic [4:0] add_a;
  logic [4:0] add_b;
  logic [4:0] add_s;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] cur_dir;
  logic       busy;
  logic       move_done;
  logic       overrun;

  modport slave (
    input  tick, dir_valid, dir, add_s,
    output add_a, add_b, head_x, head_y, cur_dir, busy, move_done, overrun
  );

  modport master (
    output tick, dir_valid, dir, add_s,
    input  add_a, add_b, head_x, head_y, cur_dir, busy, move_done, overrun
  );
endinterface

// File: rtl/snake_move_sequencer.sv
// Steps the snake head one cell per accepted tick through a time-shared adder: X then Y, toroidal wrap.
// Latency: tick at T -> X at T+1, Y at T+2, move_done at T+3; ticks outside IDLE are dropped and flagged via overrun.
module snake_move_sequencer #(
  parameter int GRID_W  = 20,
  parameter int GRID_H  = 15,
  parameter int START_X = 10,
  parameter int START_Y = 7,
  parameter int START_D = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  snake_move_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_X    = 2'd1,
    ST_Y    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [4:0] X_MAX   = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX   = 5'(GRID_H - 1);
  localparam logic [4:0] X_RST   = 5'(START_X);
  localparam logic [4:0] Y_RST   = 5'(START_Y);
  localparam logic [1:0] DIR_RST = 2'(START_D);
  localparam logic [4:0] STEP_P  = 5'd1;
  localparam logic [4:0] STEP_M  = 5'd31;

  state_t     state_q, state_d;
  logic [4:0] head_x_q, head_x_d;
  logic [4:0] head_y_q, head_y_d;
  logic [1:0] cur_dir_q, cur_dir_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic       busy_q, busy_d;
  logic       move_done_q, move_done_d;
  logic       overrun_q, overrun_d;
  logic [4:0] add_a;
  logic [4:0] add_b;
  logic [4:0] dx;
  logic [4:0] dy;

  always_comb begin
    dx = 5'd0;
    dy = 5'd0;
    case (cur_dir_q)
      DIR_RIGHT: dx = STEP_P;
      DIR_LEFT:  dx = STEP_M;
      DIR_DOWN:  dy = STEP_P;
      default:   dy = STEP_M;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    cur_dir_d   = cur_dir_q;
    pend_dir_d  = pend_dir_q;
    busy_d      = 1'b0;
    move_done_d = 1'b0;
    overrun_d   = 1'b0;
    add_a       = 5'd0;
    add_b       = 5'd0;

    // A request that would fold the snake back onto itself is discarded outright.
    if (bus.dir_valid && (bus.dir != (cur_dir_q ^ 2'b10))) begin
      pend_dir_d = bus.dir;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.tick) begin
          state_d   = ST_X;
          cur_dir_d = pend_dir_q;
          busy_d    = 1'b1;
        end
      end
      ST_X: begin
        add_a     = head_x_q;
        add_b     = dx;
        overrun_d = bus.tick;
        state_d   = ST_Y;
        busy_d    = 1'b1;
        // Wrap decided on the current coordinate so non-power-of-two grids work.
        if (cur_dir_q == DIR_RIGHT && head_x_q == X_MAX) begin
          head_x_d = 5'd0;
        end else if (cur_dir_q == DIR_LEFT && head_x_q == 5'd0) begin
          head_x_d = X_MAX;
        end else begin
          head_x_d = bus.add_s;
        end
      end
      ST_Y: begin
        add_a       = head_y_q;
        add_b       = dy;
        overrun_d   = bus.tick;
        state_d     = ST_DONE;
        move_done_d = 1'b1;
        if (cur_dir_q == DIR_DOWN && head_y_q == Y_MAX) begin
          head_y_d = 5'd0;
        end else if (cur_dir_q == DIR_UP && head_y_q == 5'd0) begin
          head_y_d = Y_MAX;
        end else begin
          head_y_d = bus.add_s;
        end
      end
      default: begin
        overrun_d = bus.tick;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      head_x_q    <= X_RST;
      head_y_q    <= Y_RST;
      cur_dir_q   <= DIR_RST;
      pend_dir_q  <= DIR_RST;
      busy_q      <= 1'b0;
      move_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      cur_dir_q   <= cur_dir_d;
      pend_dir_q  <= pend_dir_d;
      busy_q      <= busy_d;
      move_done_q <= move_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.head_x    = head_x_q;
  assign bus.head_y    = head_y_q;
  assign bus.cur_dir   = cur_dir_q;
  assign bus.busy      = busy_q;
  assign bus.move_done = move_done_q;
  assign bus.overrun   = overrun_q;

endmodule
